// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare op encodings, operand class record and
// the standard single/double field widths.
package fpu_pkg;
  localparam logic [1:0] FCMP_EQ    = 2'b00;
  localparam logic [1:0] FCMP_GT    = 2'b01;
  localparam logic [1:0] FCMP_GE    = 2'b10;
  localparam logic [1:0] FCMP_UNORD = 2'b11;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fclass_t;
endpackage

// File: rtl/fpu_fclass.sv
// Combinational unpack/classify of one packed IEEE-754 operand.
// NaN quietness follows the SH4 convention: frac MSB set means signalling.
module fpu_fclass
  import fpu_pkg::*;
#(
  parameter int EXP_W        = SP_EXP_W,
  parameter int FRAC_W       = SP_FRAC_W,
  parameter int DENORM_FLUSH = 1
) (
  input  logic [EXP_W+FRAC_W:0]   x,
  output fclass_t                 cls,
  output logic [EXP_W+FRAC_W-1:0] mag
);
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic exp_max, exp_zero, frac_zero;

  assign exp_f     = x[EXP_W+FRAC_W-1:FRAC_W];
  assign frac_f    = x[FRAC_W-1:0];
  assign mag       = x[EXP_W+FRAC_W-1:0];
  assign exp_max   = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign frac_zero = ~|frac_f;

  always_comb begin
    cls      = '0;
    cls.sign = x[EXP_W+FRAC_W];
    cls.inf  = exp_max & frac_zero;
    cls.nan  = exp_max & ~frac_zero;
    cls.snan = exp_max & ~frac_zero & frac_f[FRAC_W-1];
    // DN mode collapses every denormal onto zero before comparison
    cls.zero = exp_zero & (frac_zero | (DENORM_FLUSH != 0));
  end
endmodule

// File: rtl/fpu_fcmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator: stage 1 classifies and compares
// magnitudes, stage 2 resolves EQ/GT/GE/UNORD and drives registered results.
module fpu_fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W        = SP_EXP_W,
  parameter int FRAC_W       = SP_FRAC_W,
  parameter int DENORM_FLUSH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [1:0]            i_op,
  input  logic                  i_ven,
  input  logic [EXP_W+FRAC_W:0] i_a,
  input  logic [EXP_W+FRAC_W:0] i_b,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_t,
  output logic                  o_eq,
  output logic                  o_gt,
  output logic                  o_unordered,
  output logic                  o_invalid,
  output logic                  o_trap,
  input  logic                  flag_clr,
  output logic                  o_flag_v
);
  localparam int STAGES = 2;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MW     = EXP_W + FRAC_W;

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv, acc;

  assign s2_adv  = ~vld_pipe[2] | o_ready;
  assign s1_adv  = ~vld_pipe[1] | s2_adv;
  assign i_ready = s1_adv;
  assign acc     = i_valid & s1_adv;
  assign o_valid = vld_pipe[2];

  // operand 0 = a, operand 1 = b
  logic    [1:0][W-1:0]  opnd;
  logic    [1:0][MW-1:0] mag;
  fclass_t [1:0]         cls;

  assign opnd = {i_b, i_a};

  for (genvar g = 0; g < 2; g++) begin : g_cls
    fpu_fclass #(
      .EXP_W       (EXP_W),
      .FRAC_W      (FRAC_W),
      .DENORM_FLUSH(DENORM_FLUSH)
    ) u_fclass (
      .x  (opnd[g]),
      .cls(cls[g]),
      .mag(mag[g])
    );
  end

  fclass_t    s1_a, s1_b;
  logic       s1_mag_eq, s1_mag_gt, s1_ven;
  logic [1:0] s1_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_mag_eq   <= 1'b0;
      s1_mag_gt   <= 1'b0;
      s1_op       <= FCMP_EQ;
      s1_ven      <= 1'b0;
    end else if (s1_adv) begin
      vld_pipe[1] <= i_valid;
      if (i_valid) begin
        s1_a      <= cls[0];
        s1_b      <= cls[1];
        s1_mag_eq <= mag[0] == mag[1];
        s1_mag_gt <= mag[0] > mag[1];
        s1_op     <= i_op;
        s1_ven    <= i_ven;
      end
    end
  end

  logic any_nan, any_snan, c_eq, c_gt, c_t, c_inv;

  assign any_nan  = s1_a.nan | s1_b.nan;
  assign any_snan = s1_a.snan | s1_b.snan;

  always_comb begin
    c_eq = 1'b0;
    c_gt = 1'b0;
    if (any_nan) begin
      c_eq = 1'b0;
    end else if (s1_a.zero & s1_b.zero) begin
      c_eq = 1'b1;
    end else if (s1_a.sign != s1_b.sign) begin
      c_gt = ~s1_a.sign;
    end else if (s1_mag_eq) begin
      c_eq = 1'b1;
    end else begin
      // same sign: larger magnitude means smaller value when negative
      c_gt = s1_mag_gt ^ s1_a.sign;
    end
  end

  always_comb begin
    c_t = 1'b0;
    case (s1_op)
      FCMP_EQ:    c_t = c_eq;
      FCMP_GT:    c_t = c_gt;
      FCMP_GE:    c_t = c_gt | c_eq;
      FCMP_UNORD: c_t = any_nan;
      default:    c_t = 1'b0;
    endcase
  end

  // ordered relations trap on quiet NaNs too; EQ/UNORD only on signalling
  assign c_inv = any_snan | (any_nan & ((s1_op == FCMP_GT) | (s1_op == FCMP_GE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      o_t         <= 1'b0;
      o_eq        <= 1'b0;
      o_gt        <= 1'b0;
      o_unordered <= 1'b0;
      o_invalid   <= 1'b0;
      o_trap      <= 1'b0;
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      o_t         <= vld_pipe[1] & c_t;
      o_eq        <= vld_pipe[1] & c_eq;
      o_gt        <= vld_pipe[1] & c_gt;
      o_unordered <= vld_pipe[1] & any_nan;
      o_invalid   <= vld_pipe[1] & c_inv;
      o_trap      <= vld_pipe[1] & c_inv & s1_ven;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_flag_v <= 1'b0;
    end else if (o_valid & o_ready & o_invalid) begin
      o_flag_v <= 1'b1;
    end else if (flag_clr) begin
      o_flag_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_fcmp_pipe.sv
// Directed bench for fpu_fcmp_pipe: SP vector table plus hand sequences for
// backpressure, sticky flag, async reset and DP denormal handling.
module tb_fpu_fcmp_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_valid, i_ven, o_ready, flag_clr;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        i_ready, o_valid, o_t, o_eq, o_gt, o_un, o_inv, o_trap, o_flag;

  logic        dp_valid, dp_ven, dp_ordy, dp_clr;
  logic [1:0]  dp_op;
  logic [63:0] dp_a, dp_b;
  logic        d1_ir, d1_v, d1_t, d1_eq, d1_gt, d1_un, d1_inv, d1_trap, d1_flag;
  logic        d0_ir, d0_v, d0_t, d0_eq, d0_gt, d0_un, d0_inv, d0_trap, d0_flag;

  fpu_fcmp_pipe u_sp (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_ven(i_ven), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready),
    .o_t(o_t), .o_eq(o_eq), .o_gt(o_gt), .o_unordered(o_un), .o_invalid(o_inv),
    .o_trap(o_trap), .flag_clr(flag_clr), .o_flag_v(o_flag)
  );

  fpu_fcmp_pipe #(.EXP_W(11), .FRAC_W(52), .DENORM_FLUSH(1)) u_dp1 (
    .clk(clk), .rst_n(rst_n), .i_valid(dp_valid), .i_ready(d1_ir), .i_op(dp_op),
    .i_ven(dp_ven), .i_a(dp_a), .i_b(dp_b), .o_valid(d1_v), .o_ready(dp_ordy),
    .o_t(d1_t), .o_eq(d1_eq), .o_gt(d1_gt), .o_unordered(d1_un), .o_invalid(d1_inv),
    .o_trap(d1_trap), .flag_clr(dp_clr), .o_flag_v(d1_flag)
  );

  fpu_fcmp_pipe #(.EXP_W(11), .FRAC_W(52), .DENORM_FLUSH(0)) u_dp0 (
    .clk(clk), .rst_n(rst_n), .i_valid(dp_valid), .i_ready(d0_ir), .i_op(dp_op),
    .i_ven(dp_ven), .i_a(dp_a), .i_b(dp_b), .o_valid(d0_v), .o_ready(dp_ordy),
    .o_t(d0_t), .o_eq(d0_eq), .o_gt(d0_gt), .o_unordered(d0_un), .o_invalid(d0_inv),
    .o_trap(d0_trap), .flag_clr(dp_clr), .o_flag_v(d0_flag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // {valid,t,eq,gt,unordered,invalid,trap}
  function automatic logic [7:0] sp_res();
    return {1'b0, o_valid, o_t, o_eq, o_gt, o_un, o_inv, o_trap};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic        ven;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  res;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic [1:0] op, input logic ven, input logic [31:0] a,
                       input logic [31:0] b);
    i_valid = 1'b1; i_op = op; i_ven = ven; i_a = a; i_b = b;
  endtask

  task automatic dp_vec(input string name, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic t1, input logic t0);
    @(negedge clk);
    dp_valid = 1'b1; dp_op = op; dp_a = a; dp_b = b;
    @(negedge clk);
    dp_valid = 1'b0;
    @(negedge clk);
    chk({name, "_flush"},   {6'd0, d1_v, d1_t}, {6'd0, 1'b1, t1});
    chk({name, "_noflush"}, {6'd0, d0_v, d0_t}, {6'd0, 1'b1, t0});
  endtask

  initial begin
    tbl[0]  = '{2'b00, 1'b0, 32'h3F800000, 32'h3F800000, 7'b1110000};
    tbl[1]  = '{2'b01, 1'b0, 32'h40000000, 32'h3F800000, 7'b1101000};
    tbl[2]  = '{2'b01, 1'b0, 32'hBF800000, 32'hC0000000, 7'b1101000};
    tbl[3]  = '{2'b00, 1'b0, 32'h00000000, 32'h80000000, 7'b1110000};
    tbl[4]  = '{2'b01, 1'b0, 32'h7F800000, 32'h7F7FFFFF, 7'b1101000};
    tbl[5]  = '{2'b10, 1'b0, 32'hFF800000, 32'hFF800000, 7'b1110000};
    tbl[6]  = '{2'b00, 1'b1, 32'h7F800001, 32'h3F800000, 7'b1000100};
    tbl[7]  = '{2'b01, 1'b1, 32'h7F800001, 32'h3F800000, 7'b1000111};
    tbl[8]  = '{2'b00, 1'b0, 32'h7FC00000, 32'h3F800000, 7'b1000110};
    tbl[9]  = '{2'b11, 1'b1, 32'h7F800001, 32'h3F800000, 7'b1100100};
    tbl[10] = '{2'b11, 1'b1, 32'h3F800000, 32'h7FC00000, 7'b1100111};
    tbl[11] = '{2'b10, 1'b0, 32'h3F800000, 32'h40000000, 7'b1000000};
    tbl[12] = '{2'b01, 1'b0, 32'hFF800000, 32'hBF800000, 7'b1000000};
    tbl[13] = '{2'b10, 1'b0, 32'h80000000, 32'h3F800000, 7'b1000000};
    tbl[14] = '{2'b00, 1'b0, 32'h00000001, 32'h00000000, 7'b1110000};

    rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_ven = 1'b0; i_a = '0; i_b = '0;
    o_ready = 1'b1; flag_clr = 1'b0;
    dp_valid = 1'b0; dp_op = 2'b00; dp_ven = 1'b0; dp_a = '0; dp_b = '0;
    dp_ordy = 1'b1; dp_clr = 1'b0;
    #12;
    chk("reset_outputs", sp_res(), 8'h00);
    chk("reset_ready_flag", {6'd0, i_ready, o_flag}, 8'b10);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back table: vector k driven at iteration k, result seen at k+2
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i >= 2) chk($sformatf("vec%0d", i - 2), sp_res(), {1'b0, tbl[i-2].res});
      if (i < 15) drive(tbl[i].op, tbl[i].ven, tbl[i].a, tbl[i].b);
      else i_valid = 1'b0;
    end
    @(negedge clk);
    chk("drained_zero", sp_res(), 8'h00);
    chk("flag_after_table", {7'd0, o_flag}, 8'd1);

    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("flag_clr_alone", {7'd0, o_flag}, 8'd0);

    // invalid handshake coinciding with flag_clr: set must win
    drive(2'b01, 1'b1, 32'h7F800001, 32'h3F800000);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("flag_seq_inv", sp_res(), 8'b01000111);
    flag_clr = 1'b1;
    @(negedge clk);
    chk("flag_set_wins", {7'd0, o_flag}, 8'd1);
    @(negedge clk);
    flag_clr = 1'b0;
    chk("flag_clr_after", {7'd0, o_flag}, 8'd0);

    // backpressure: three beats offered while o_ready is low
    o_ready = 1'b0;
    drive(2'b00, 1'b0, 32'h3F800000, 32'h3F800000);
    chk("bp_rdy_a", {7'd0, i_ready}, 8'd1);
    @(negedge clk);
    drive(2'b01, 1'b0, 32'h40000000, 32'h3F800000);
    chk("bp_rdy_b", {7'd0, i_ready}, 8'd1);
    @(negedge clk);
    drive(2'b11, 1'b0, 32'h7F800001, 32'h3F800000);
    chk("bp_full_0", {7'd0, i_ready}, 8'd0);
    chk("bp_hold_a0", sp_res(), 8'b01110000);
    @(negedge clk);
    chk("bp_full_1", {7'd0, i_ready}, 8'd0);
    chk("bp_hold_a1", sp_res(), 8'b01110000);
    @(negedge clk);
    chk("bp_full_2", {7'd0, i_ready}, 8'd0);
    chk("bp_hold_a2", sp_res(), 8'b01110000);
    o_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {7'd0, i_ready}, 8'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk("bp_drain_b", sp_res(), 8'b01101000);
    @(negedge clk);
    chk("bp_drain_c", sp_res(), 8'b01100100);
    @(negedge clk);
    chk("bp_drain_end", sp_res(), 8'h00);

    // async reset mid-stream with the flag set and a result held
    drive(2'b01, 1'b0, 32'h7F800001, 32'h3F800000);
    @(negedge clk);
    drive(2'b00, 1'b0, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    o_ready = 1'b0;
    chk("pre_rst_state", {6'd0, o_valid, o_flag}, 8'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", sp_res(), 8'h00);
    chk("async_rst_flag", {6'd0, i_ready, o_flag}, 8'b10);
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = 1'b1;

    dp_vec("dp_gt_ulp", 2'b01, 64'h3FF0000000000001, 64'h3FF0000000000000, 1'b1, 1'b1);
    dp_vec("dp_eq_den", 2'b00, 64'h0000000000000001, 64'h0000000000000000, 1'b1, 1'b0);
    dp_vec("dp_gt_den", 2'b01, 64'h0000000000000001, 64'h0000000000000000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_fcmp_pipe.md
Name: fpu_fcmp_pipe

Overview:
Parametrised, pipelined IEEE-754 comparator for the FPU datapath. Handles single or double precision via EXP_W/FRAC_W, unpacks and classifies packed operands internally, and evaluates EQ/GT/GE/UNORD per transaction. It has 2-stage valid/ready flow control, an FPSCR-style sticky invalid flag and an invalid-trap output. It sits between the FPU operand read stage and the T-bit/FPSCR writeback.

Parameters:
EXP_W, 8, exponent width (11 for double)
FRAC_W, 23, fraction width (52 for double)
DENORM_FLUSH, 1, 1: exp==0 operands treated as zero (DN mode); 0: compared as denormals

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_valid  in  1  operand beat valid
i_ready  out  1  block can accept a beat
i_op  in  2  00 EQ, 01 GT (a>b), 10 GE (a>=b), 11 UNORD
i_ven  in  1  invalid-exception enable, sampled with the beat
i_a  in  1+EXP_W+FRAC_W  operand a, packed {sign,exp,frac}
i_b  in  1+EXP_W+FRAC_W  operand b, packed
o_valid  out  1  result valid
o_ready  in  1  consumer accepts result
o_t  out  1  T-bit result for i_op
o_eq  out  1  a==b (ordered)
o_gt  out  1  a>b (ordered)
o_unordered  out  1  either operand NaN
o_invalid  out  1  invalid condition for this result
o_trap  out  1  o_invalid && captured i_ven
flag_clr  in  1  clear sticky flag
o_flag_v  out  1  sticky invalid flag

Behaviour:
- Reset is asynchronous and active-low on rst_n. All pipeline valids, all result outputs and o_flag_v reset to 0. In-flight beats are discarded; there is no replay.
- Reset gives i_ready=1 (stage 1 empty).
- Pipeline:
  - Stage 1 registers the classification (zero/inf/nan/snan per operand), signs, the {exp,frac} magnitude eq/gt, i_op and i_ven.
  - Stage 2 registers all o_* result outputs.
  - Latency is 2 cycles from accept to o_valid with no stall. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !o_valid || o_ready.
  - s1_adv = !s1_valid || s2_adv.
  - i_ready = s1_adv, combinational, with no dependency on i_valid.
  - Accept on i_valid && i_ready. o_valid holds and outputs stay stable until o_ready.
- Classification:
  - exp all-ones, frac==0 → inf.
  - exp all-ones, frac!=0 → NaN. sNaN when frac MSB=1; qNaN when frac MSB=0 (SH4 convention).
  - exp==0 → zero if frac==0, or always when DENORM_FLUSH=1.
- Compare rules, applied in order:
  1. Any NaN → eq=gt=0, unordered=1.
  2. Both zero → eq=1 regardless of sign.
  3. Signs differ → gt = !a_sign.
  4. Same sign → unsigned compare of {exp,frac}. Equal → eq=1. Otherwise gt = mag_gt XOR sign.
- Infinities fall out of the magnitude compare: +inf==+inf, and -inf<-1.0.
- o_t by op: EQ → eq; GT → gt; GE → gt|eq; UNORD → unordered.
- Invalid:
  - Any sNaN, for all ops.
  - Any NaN including qNaN, for GT and GE.
  - UNORD raises invalid only on sNaN.
- o_trap = o_invalid && i_ven captured with that beat.
- Sticky flag:
  - o_flag_v sets on an output handshake (o_valid&&o_ready) carrying o_invalid.
  - It clears on flag_clr.
  - Simultaneous set and clear → flag = 1 (set wins).
- Outputs are registered. o_t/o_eq/o_gt/o_unordered/o_invalid/o_trap are 0 when o_valid=0.

Decomposition:
- Shared package fpu_pkg holds:
  - op encodings FCMP_EQ/GT/GE/UNORD;
  - class struct {sign, zero, inf, nan, snan};
  - default SP/DP EXP_W/FRAC_W constants.
- One sub-module, fpu_fclass: parametrised combinational unpack/classify, instantiated twice in stage 1 and reusable by other FPU units.

Test Plan:
- SP, back-to-back beats, o_ready=1:
  - EQ 0x3F800000 vs 0x3F800000 → t=1 at cycle+2;
  - GT 0x40000000 vs 0x3F800000 → t=1;
  - GT 0xBF800000 vs 0xC0000000 → t=1;
  - one result per cycle.
- Zeros/inf, SP:
  - EQ 0x00000000 vs 0x80000000 → t=1, eq=1;
  - GT 0x7F800000 vs 0x7F7FFFFF → t=1;
  - GE 0xFF800000 vs 0xFF800000 → t=1.
- NaN, SP:
  - EQ qNaN 0x7F800001 vs 1.0 → t=0, unordered=1, invalid=0;
  - GT same → invalid=1, trap=1 if ven=1, flag sets.
  - EQ sNaN 0x7FC00000 → invalid=1.
- Backpressure: hold o_ready=0 for 4 cycles with 3 beats offered → 2 accepted, then i_ready=0. Outputs stay stable. On release, results drain in order with no loss or duplication.
- Sticky flag: invalid result handshake in the same cycle as flag_clr → o_flag_v=1. A following flag_clr alone → 0. rst_n low mid-stream → o_valid=0 and flag=0 immediately (async).
- DP instance (EXP_W=11, FRAC_W=52): GT 0x3FF0000000000001 vs 0x3FF0000000000000 → t=1. Denormal 0x0000000000000001 vs 0 with DENORM_FLUSH=1 → EQ t=1; with DENORM_FLUSH=0 → EQ t=0, GT t=1.
